sel_decoder: RTL

SEL_DECODER -- requirements
Module: sel_decoder

---
 rtl/sel_decoder.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/sel_decoder.sv
// Registered one-hot select decoder with a request/done handshake and IDLE/SELECT FSM.
// Define SEL_DECODER_TIMEOUT_EN to compile in a SELECT-state timeout watchdog that drives tmo.
module sel_decoder #(
  parameter int unsigned IN_W    = 3,
  parameter int unsigned NUM_OUT = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic               CLK,
  input  logic               RESETn,
  input  logic               enable,
  input  logic               req_valid,
  input  logic [IN_W-1:0]    req_idx,
  output logic               req_ready,
  input  logic               done,
  output logic [NUM_OUT-1:0] sel_out,
  output logic               active,
  output logic               err,
  output logic               tmo
);

  if (IN_W < 1 || IN_W > 8 || NUM_OUT < 2 || NUM_OUT > (1 << IN_W) ||
      TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_params
    $error("sel_decoder: parameter out of range");
  end

  typedef enum logic {StIdle, StSelect} state_e;

  state_e             state_q, state_d;
  logic [NUM_OUT-1:0] sel_q, sel_d;
  logic [NUM_OUT-1:0] dec;
  logic               err_q, err_d;
  logic               accept;
  logic               in_range;

  // Reset gating keeps req_ready low for the whole reset window.
  assign req_ready = (state_q == StIdle) && enable && RESETn;
  assign accept    = req_valid && enable && (state_q == StIdle);
  assign in_range  = {{(32 - IN_W){1'b0}}, req_idx} < NUM_OUT;

  always_comb begin
    dec = '0;
    for (int unsigned i = 0; i < NUM_OUT; i++) begin
      if (req_idx == IN_W'(i)) dec[i] = 1'b1;
    end
  end

`ifdef SEL_DECODER_TIMEOUT_EN
  localparam logic [7:0] TmoLast = 8'(TIMEOUT - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       tmo_q, tmo_d;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    err_d   = 1'b0;
    tmo_d   = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          if (in_range) begin
            state_d = StSelect;
            sel_d   = dec;
            cnt_d   = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StSelect: begin
        // A normal exit (done or disable) wins over an expiring watchdog.
        if (!enable || done) begin
          state_d = StIdle;
          sel_d   = '0;
        end else if (cnt_q == TmoLast) begin
          state_d = StIdle;
          sel_d   = '0;
          tmo_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = StIdle;
        sel_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
    end
  end

  assign tmo = tmo_q;
`else
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    err_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (accept) begin
          if (in_range) begin
            state_d = StSelect;
            sel_d   = dec;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StSelect: begin
        if (!enable || done) begin
          state_d = StIdle;
          sel_d   = '0;
        end
      end
      default: begin
        state_d = StIdle;
        sel_d   = '0;
      end
    endcase
  end

  assign tmo = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= StIdle;
      sel_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      err_q   <= err_d;
    end
  end

  assign sel_out = sel_q;
  assign active  = (state_q == StSelect);
  assign err     = err_q;

endmodule
